fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding scoreboard for the pipelined MIPS core; generalises fixed per-port forward muxes.
//  Tracks in-flight register writes in an NSTAGE-deep shift register of {valid, wa, tnew} after D.
//  Per D-stage read port, emits a forward-source select, a pending flag and a global stall.
//  Sits beside the D/E pipeline registers; its selects drive the D-stage forward muxes.
// PARAMETERS
//  NSTAGE  3  tracked stages after D (1=E, 2=M, 3=W); the last stage retires to the RF
//  NRD     2  number of D-stage register read ports
//  AW      5  register address width
//  TW      2  tnew/tuse counter width
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-low reset
//  d_valid     in   1           D holds a real instruction
//  d_we        in   1           D instruction writes a register
//  d_wa        in   AW          D destination register
//  d_tnew      in   TW          cycles after entering E until result valid
//  d_ra        in   NRD*AW      read addresses, port i at [i*AW +: AW]
//  d_tuse      in   NRD*TW      cycles after D until port i value is consumed
//  ext_stall   in   1           external D hold (e.g. MDU busy)
//  stall       out  1           freeze PC and F/D; insert bubble into E
//  fwd_sel     out  NRD*SW      SW=$clog2(NSTAGE+1); 0=RF, k=stage k result
//  fwd_pend    out  NRD         matching producer not ready but tnew<=tuse
//  stall_cnt   out  32          stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset low): all entries invalid, tnew=0; stall=0, fwd_sel=0, fwd_pend=0, stall_cnt=0.
//  - Entry alloc: valid = d_valid & d_we & (d_wa!=0) & ~stall.
//    Under stall, stage 1 loads a bubble (valid=0).
//  - Every clk: stage k+1 <= stage k (k=1..NSTAGE-1); stage NSTAGE retires and is dropped.
//    Each shifted entry's tnew decrements, saturating at 0.
//  - Stage 1 loads d_tnew unmodified.
//  - Lookup, per port i (combinational, same cycle):
//    - d_ra==0: sel=0, pend=0, no stall contribution.
//    - Otherwise take the youngest (lowest k) valid entry with wa==d_ra; no match: sel=0, pend=0.
//    - Match tnew==0: sel=k, pend=0.
//    - Match 0<tnew<=tuse: sel=0, pend=1, no stall.
//    - Match tnew>tuse: sel=0, pend=0, port requests stall.
//  - Outputs: stall = OR of port requests | ext_stall. Forward/stall evaluation is not gated by d_valid.
//  - Comparisons are unsigned TW-bit; no internal latency beyond the shift register.
//  - Reset mid-operation discards all in-flight entries immediately.
//  - Simultaneous stall and retire: the shift still occurs, so the stall resolves as producers advance.
//  - Tnew saturating at 0 in the last stage is legal; the entry retires the next clk.
// CONFIGURATION
//  - FWD_SCB_PERF_EN defined: stall_cnt increments by 1 each clk with stall=1.
//    It wraps 0xFFFFFFFF->0 and clears only on reset.
//  - Not defined: stall_cnt is constant 0 and no counter flops are built.
// TESTING  (NSTAGE=3, NRD=2, TW=2)
//  - Reset low, any inputs -> stall=0, fwd_sel=0, fwd_pend=0; after release, reads of $8 -> sel 0.
//  - addu $8 issues tnew=1; next cycle beq reads $8 tuse=0 -> stall=1.
//    The following cycle: stall=0, fwd_sel[0]=2 (M).
//  - lw $9 tnew=2; next cycle addu reads $9 tuse=1 -> stall=1 for one cycle.
//    Then stall=0, fwd_pend[0]=1, fwd_sel[0]=0.
//  - jal writes $31 tnew=0, then addu $31 tnew=1; reader $31 tuse=0 -> matches stage 1 (addu), stall=1.
//    The next cycle: sel=2.
//  - Port reads $0 while an entry with wa=0 is presented -> never allocated; sel=0, stall=0.
//  - ext_stall high 3 cycles with FWD_SCB_PERF_EN -> 3 bubbles enter E, stall_cnt=3.
//    Without the macro, stall_cnt=0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: hazard/forwarding scoreboard for the pipelined MIPS core.
// Tracks in-flight register writes in an NSTAGE-deep shift register behind D.
// For every D-stage read port it produces a forward-source select, a pending
// flag, and a global stall request.
// Optional build macro FWD_SCB_PERF_EN adds a 32-bit stall-cycle counter on
// stall_cnt. Without the macro, stall_cnt is tied to 0 and no counter flops
// are built.
module fwd_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int NRD    = 2,
  parameter int AW     = 5,
  parameter int TW     = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                d_valid,
  input  logic                                d_we,
  input  logic [AW-1:0]                       d_wa,
  input  logic [TW-1:0]                       d_tnew,
  input  logic [NRD*AW-1:0]                   d_ra,
  input  logic [NRD*TW-1:0]                   d_tuse,
  input  logic                                ext_stall,
  output logic                                stall,
  output logic [NRD*$clog2(NSTAGE+1)-1:0]     fwd_sel,
  output logic [NRD-1:0]                      fwd_pend,
  output logic [31:0]                         stall_cnt
);

  localparam int SW = $clog2(NSTAGE + 1);

  // Tnew counts down as a producer advances but never goes below zero.
  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Per-stage entry: index 1 is E, index NSTAGE is the last tracked stage.
  logic          vld_p  [1:NSTAGE];
  logic [AW-1:0] wa_p   [1:NSTAGE];
  logic [TW-1:0] tnew_p [1:NSTAGE];

  logic          alloc;
  logic [NRD-1:0] req;
  logic [AW-1:0] ra;
  logic [TW-1:0] tuse;
  logic [TW-1:0] htnew;
  logic          hit;
  int            hk;

  // Writes to $0 are never tracked, and a stalled D enters E as a bubble.
  assign alloc = d_valid & d_we & (d_wa != '0) & ~stall;

  // Control state: valid bits and tnew counters advance every clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        vld_p[k]  <= 1'b0;
        tnew_p[k] <= '0;
      end
    end else begin
      vld_p[1]  <= alloc;
      tnew_p[1] <= alloc ? d_tnew : '0;
      for (int k = 2; k <= NSTAGE; k++) begin
        vld_p[k]  <= vld_p[k-1];
        tnew_p[k] <= dec_sat(tnew_p[k-1]);
      end
    end
  end

  // Destination addresses follow their valid bits; no reset is needed.
  always_ff @(posedge clk) begin
    wa_p[1] <= d_wa;
    for (int k = 2; k <= NSTAGE; k++) begin
      wa_p[k] <= wa_p[k-1];
    end
  end

  // Per-port lookup: youngest matching producer decides forward, pend or stall.
  always_comb begin
    req      = '0;
    fwd_sel  = '0;
    fwd_pend = '0;
    ra       = '0;
    tuse     = '0;
    htnew    = '0;
    hit      = 1'b0;
    hk       = 0;
    for (int i = 0; i < NRD; i++) begin
      ra    = d_ra[i*AW +: AW];
      tuse  = d_tuse[i*TW +: TW];
      hit   = 1'b0;
      hk    = 0;
      htnew = '0;
      // Scan oldest to youngest so the youngest match overrides.
      for (int k = NSTAGE; k >= 1; k--) begin
        if (vld_p[k] && (wa_p[k] == ra)) begin
          hit   = 1'b1;
          hk    = k;
          htnew = tnew_p[k];
        end
      end
      if ((ra != '0) && hit) begin
        if (htnew == '0) begin
          fwd_sel[i*SW +: SW] = SW'(hk);
        end else if (htnew <= tuse) begin
          fwd_pend[i] = 1'b1;
        end else begin
          req[i] = 1'b1;
        end
      end
    end
  end

  // Stall is forced low while reset is held, whatever the inputs do.
  assign stall = reset & ((|req) | ext_stall);

`ifdef FWD_SCB_PERF_EN
  logic [31:0] cnt_q;

  // Count every clock spent stalled; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Testbench for fwd_scoreboard (NSTAGE=3, NRD=2, AW=5, TW=2): directed hazard
// scenarios plus randomized traffic against an issue-history reference model.
module tb_fwd_scoreboard;

  localparam int NSTAGE = 3;
  localparam int NRD    = 2;
  localparam int AW     = 5;
  localparam int TW     = 2;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic        d_we;
  logic [4:0]  d_wa;
  logic [1:0]  d_tnew;
  logic [9:0]  d_ra;
  logic [3:0]  d_tuse;
  logic        ext_stall;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [1:0]  fwd_pend;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  fwd_scoreboard #(.NSTAGE(NSTAGE), .NRD(NRD), .AW(AW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_we(d_we), .d_wa(d_wa),
    .d_tnew(d_tnew), .d_ra(d_ra), .d_tuse(d_tuse), .ext_stall(ext_stall),
    .stall(stall), .fwd_sel(fwd_sel), .fwd_pend(fwd_pend), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of issued writes, each with its age in cycles.
  typedef struct {
    logic [4:0] wa;
    int         tnew;
    int         age;
  } ent_t;

  ent_t hist[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic we, input logic [4:0] wa,
                       input logic [1:0] tn, input logic [4:0] ra0, input logic [1:0] tu0,
                       input logic [4:0] ra1, input logic [1:0] tu1, input logic ext);
    d_valid   = v;
    d_we      = we;
    d_wa      = wa;
    d_tnew    = tn;
    d_ra      = {ra1, ra0};
    d_tuse    = {tu1, tu0};
    ext_stall = ext;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_d(1, 1, 5'd8, 2'd3, 5'd8, 2'd0, 5'd8, 2'd0, 1'b1);
    #2;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++;
    if (fwd_sel !== 4'd0 || fwd_pend !== 2'd0) begin
      errors++; $display("FAIL reset_fwd sel=%h pend=%b want 0/0", fwd_sel, fwd_pend);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    reset = 1'b1;
    set_d(0, 0, 0, 0, 5'd8, 2'd0, 5'd8, 2'd3, 1'b0);
    #2;
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL post_reset_read sel=%h stall=%b want 0/0", fwd_sel, stall);
    end
    tick();
  endtask

  task automatic test_alu_branch();
    do_reset();
    set_d(1, 1, 5'd8, 2'd1, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 0, 5'd0, 2'd0, 5'd8, 2'd0, 0, 0, 0);
    #2;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL alu_br_stall got %b want 1", stall); end
    tick();
    #2;
    checks++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2 || fwd_pend !== 2'd0) begin
      errors++; $display("FAIL alu_br_fwd stall=%b sel0=%0d pend=%b want 0/2/00", stall, fwd_sel[1:0], fwd_pend);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1, 1, 5'd9, 2'd2, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 1, 5'd10, 2'd1, 5'd9, 2'd1, 0, 0, 0);
    #2;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", stall); end
    tick();
    #2;
    checks++;
    if (stall !== 1'b0 || fwd_pend[0] !== 1'b1 || fwd_sel[1:0] !== 2'd0) begin
      errors++; $display("FAIL load_use_pend stall=%b pend0=%b sel0=%0d want 0/1/0", stall, fwd_pend[0], fwd_sel[1:0]);
    end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    set_d(1, 1, 5'd31, 2'd0, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 1, 5'd31, 2'd1, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd31, 2'd0, 0);
    #2;
    checks++;
    if (stall !== 1'b1 || fwd_sel[3:2] !== 2'd0) begin
      errors++; $display("FAIL youngest_stall stall=%b sel1=%0d want 1/0", stall, fwd_sel[3:2]);
    end
    tick();
    #2;
    checks++;
    if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2) begin
      errors++; $display("FAIL youngest_fwd stall=%b sel1=%0d want 0/2", stall, fwd_sel[3:2]);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_d(1, 1, 5'd0, 2'd3, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 0);
    #2;
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0 || fwd_pend !== 2'd0) begin
      errors++; $display("FAIL zero_reg stall=%b sel=%h pend=%b want 0/0/0", stall, fwd_sel, fwd_pend);
    end
    tick();
  endtask

  task automatic test_ext_stall();
    logic [31:0] exp_cnt;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_d(1, 1, 5'd5, 2'd0, 0, 0, 0, 0, 1);
      #2;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL ext_stall_c%0d got %b want 1", c, stall); end
      tick();
    end
    set_d(1, 1, 5'd6, 2'd0, 5'd5, 2'd0, 0, 0, 0);
    #2;
`ifdef FWD_SCB_PERF_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
      errors++; $display("FAIL ext_bubbles stall=%b sel=%h want 0/0", stall, fwd_sel);
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL ext_cnt got %0d want %0d", stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_d(1, 1, 5'd7, 2'd0, 0, 0, 0, 0, 0);
    tick();
    set_d(0, 0, 0, 0, 5'd7, 2'd0, 0, 0, 0);
    #2;
    checks++;
    if (fwd_sel[1:0] !== 2'd1) begin errors++; $display("FAIL midflight_pre sel0=%0d want 1", fwd_sel[1:0]); end
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL midflight_post sel=%h stall=%b want 0/0", fwd_sel, stall);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0]  ra [2];
    logic [1:0]  tu [2];
    logic [3:0]  exp_sel;
    logic [1:0]  exp_pend;
    logic        exp_stall;
    logic [31:0] mcnt;
    logic [31:0] exp_cnt;
    logic        v, we, ext;
    logic [4:0]  wa;
    logic [1:0]  tn;
    ent_t        e;
    do_reset();
    hist.delete();
    mcnt = 32'd0;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 7) != 0);
      we   = ($urandom_range(0, 3) != 0);
      wa   = 5'($urandom_range(0, 3));
      tn   = 2'($urandom_range(0, 3));
      ra[0] = 5'($urandom_range(0, 3));
      ra[1] = 5'($urandom_range(0, 3));
      tu[0] = 2'($urandom_range(0, 3));
      tu[1] = 2'($urandom_range(0, 3));
      ext  = ($urandom_range(0, 7) == 0);
      set_d(v, we, wa, tn, ra[0], tu[0], ra[1], tu[1], ext);
      // Expected outputs from the history: youngest write to the register wins.
      exp_sel   = '0;
      exp_pend  = '0;
      exp_stall = ext;
      for (int p = 0; p < 2; p++) begin
        int best_age;
        int left;
        best_age = 0;
        left     = 0;
        foreach (hist[j]) begin
          if (hist[j].wa == ra[p] && (best_age == 0 || hist[j].age < best_age)) begin
            best_age = hist[j].age;
            left     = hist[j].tnew - (hist[j].age - 1);
            if (left < 0) left = 0;
          end
        end
        if (ra[p] != 0 && best_age != 0) begin
          if (left == 0)            exp_sel[p*2 +: 2] = 2'(best_age);
          else if (left <= int'(tu[p])) exp_pend[p] = 1'b1;
          else                      exp_stall = 1'b1;
        end
      end
`ifdef FWD_SCB_PERF_EN
      exp_cnt = mcnt;
`else
      exp_cnt = 32'd0;
`endif
      #2;
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL rnd_stall c=%0d got %b want %b", c, stall, exp_stall);
      end
      checks++;
      if (fwd_sel !== exp_sel) begin
        errors++; $display("FAIL rnd_sel c=%0d got %h want %h", c, fwd_sel, exp_sel);
      end
      checks++;
      if (fwd_pend !== exp_pend) begin
        errors++; $display("FAIL rnd_pend c=%0d got %b want %b", c, fwd_pend, exp_pend);
      end
      checks++;
      if (stall_cnt !== exp_cnt) begin
        errors++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, stall_cnt, exp_cnt);
      end
      tick();
      // Advance history: everything ages, old writes leave, new write enters.
      for (int j = hist.size() - 1; j >= 0; j--) begin
        hist[j].age++;
        if (hist[j].age > NSTAGE) hist.delete(j);
      end
      if (v && we && wa != 0 && !exp_stall) begin
        e.wa   = wa;
        e.tnew = int'(tn);
        e.age  = 1;
        hist.push_back(e);
      end
      if (exp_stall) mcnt = mcnt + 32'd1;
    end
  endtask

  initial begin
    reset = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_alu_branch();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_ext_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
